adc128s102_scan_ctrl: RTL and testbench
=======================================

Name: adc128s102_scan_ctrl

Overview:
- Scan sequencer and SPI master for the ADC128S102 8-channel 12-bit ADC.
- Converts each channel set in a channel-enable mask, in ascending channel order, within one CS-low burst.
- Owns the full SPI pin set (cs_out, sclk_out, sdin, sdout).
- Returns tagged 12-bit results to the fabric, replacing free-running, hand-written configuration streams with a controlled, requestable scan.

Parameters:
- CLK_DIV, 2: sys_clk cycles per SCLK half-period; legal range 2..255. Default gives 12.5 MHz SCLK from a 50 MHz sys_clk.
- BURST_GAP, 4: sys_clk cycles cs_out is held high after a burst before the next start is accepted; legal range 1..255.

Ports:
- sys_clk  in  1  system clock, 50 MHz.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle scan request; sampled only in IDLE.
- ch_mask  in  8  channel enable; bit n = IN n; latched on accepted start.
- busy  out  1  high from the cycle after an accepted start until back in IDLE.
- data_valid  out  1  one-cycle result strobe.
- data_ch  out  3  channel of the current result; valid with data_valid.
- data_out  out  12  conversion result; valid with data_valid.
- frame_err  out  1  leading-zero check failure; valid with data_valid.
- sdout  in  1  ADC DOUT.
- sclk_out  out  1  ADC SCLK; idles high.
- cs_out  out  1  ADC CS, active low.
- sdin  out  1  ADC DIN.

Behaviour:
- Reset, including mid-burst, takes effect on the next sys_clk edge: state=IDLE, cs_out=1, sclk_out=1, sdin=0, busy=0, data_valid=0, data_ch=0, data_out=0, frame_err=0. A partially shifted frame is discarded and produces no data_valid.
- States:
  - IDLE: start=1 and ch_mask!=0 -> latch mask, build ascending channel list of N entries -> CS_SETUP. start with ch_mask==0 is ignored; busy stays 0. start outside IDLE is ignored.
  - CS_SETUP: cs_out=0 and sclk_out=1 for CLK_DIV cycles; sdin=bit15 of frame 0 -> SHIFT.
  - SHIFT: 16 SCLK periods. Each period is CLK_DIV cycles low, then CLK_DIV cycles high.
    - Period i (0..15): sdin=control word bit (15-i), updated on the cycle sclk_out falls.
    - sdout is shifted in MSB-first on the cycle sclk_out rises.
    - After the 16th rising edge -> FRAME_END.
  - FRAME_END: one cycle. If frame index k>=1: data_valid=1, data_ch = channel addressed in frame k-1, data_out = captured bits[11:0]. If more frames remain -> SHIFT with cs_out held low and no SCLK gap; else -> GAP.
  - GAP: cs_out=1, sclk_out=1 for BURST_GAP cycles -> IDLE.
- Frame scheduling:
  - A burst contains N+1 frames.
  - Frame k (0..N-1) addresses list[k]; frame N addresses list[N-1] again as a dummy.
  - Frame 0 read data is discarded, because the ADC returns the previous address's conversion.
- Control word: bits[13:11] = channel, all other bits 0. Examples: ch0=0x0000, ch2=0x1000, ch5=0x2800, ch7=0x3800.
- data_out/data_ch/frame_err hold their values between strobes.
- busy drops in the cycle IDLE is re-entered.
- Burst length in sys_clk cycles: CLK_DIV + (N+1)*(32*CLK_DIV+1) + BURST_GAP.

Optional Feature:
- Macro ADC_FRAME_CHECK_EN.
- Defined: the four leading DOUT bits (captured bits[15:12]) are checked per frame. frame_err=1 with data_valid if any bit is nonzero; data is still delivered.
- Undefined: no check logic; frame_err tied 0.

Test Plan:
- Reset then idle, 100 cycles -> cs_out=1, sclk_out=1, busy=0, data_valid never asserted.
- start with ch_mask=0x05, ADC model returns 0xABC for IN0 and 0x123 for IN2 -> 3 frames; DIN words 0x0000, 0x1000, 0x1000; exactly 2 data_valid pulses: (ch0, 0xABC) then (ch2, 0x123); busy high for 2+3*65+4 cycles.
- start with ch_mask=0x00 -> no CS activity, busy stays 0. start pulsed again while busy -> ignored, single burst only.
- ch_mask=0xFF -> 9 frames, data_ch sequence 0..7, DIN bits[13:11] sequence 0..7 then 7; cs_out stays low continuously across all 9 frames.
- reset asserted during frame 2 of a 0x0F scan -> next cycle cs_out=1, sclk_out=1, busy=0; no further data_valid; a fresh start with mask 0x02 completes normally with (ch1) result.
- ADC_FRAME_CHECK_EN defined, model drives DOUT bit15=1 on the IN3 frame -> frame_err=1 only with the ch3 strobe, data_out still correct; undefined -> frame_err=0 throughout.

Source files
------------

// File: rtl/adc128s102_scan_ctrl.sv
// adc128s102_scan_ctrl
// Scan sequencer and SPI master for the ADC128S102 (8 channels, 12 bits).
// A one-cycle start in IDLE with a nonzero ch_mask runs one CS-low burst.
// The burst converts every enabled channel in ascending order. It holds
// N+1 frames: the ADC returns the previous frame's address, so frame 0 is
// discarded and a dummy frame repeats the last channel to collect its result.
//
// Ports:
//   sys_clk, reset   system clock, synchronous active-high reset
//   start, ch_mask   scan request (IDLE only) and channel-enable mask
//   busy             high while a burst is in progress
//   data_valid       one-cycle result strobe with data_ch/data_out/frame_err
//   sdout            ADC DOUT
//   sclk_out, cs_out, sdin   ADC SCLK (idles high), CS (active low), DIN
//
// Optional feature: define ADC_FRAME_CHECK_EN to flag frames whose four
// leading DOUT bits are not zero (frame_err). When it is not defined,
// frame_err is tied low.
module adc128s102_scan_ctrl #(
  parameter int CLK_DIV   = 2,
  parameter int BURST_GAP = 4
) (
  input  logic        sys_clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  ch_mask,
  output logic        busy,
  output logic        data_valid,
  output logic [2:0]  data_ch,
  output logic [11:0] data_out,
  output logic        frame_err,
  input  logic        sdout,
  output logic        sclk_out,
  output logic        cs_out,
  output logic        sdin
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LAST = 8'(BURST_GAP - 1);
`ifdef ADC_FRAME_CHECK_EN
  localparam int SHIFT_W = 16;
`else
  localparam int SHIFT_W = 12;
`endif

  typedef enum logic [2:0] {S_IDLE, S_CS_SETUP, S_SHIFT, S_FRAME_END, S_GAP} state_t;

  // Control word: channel address in bits[13:11], all other bits zero.
  function automatic logic [15:0] ctrl_word(input logic [2:0] ch);
    return {2'b00, ch, 11'b000_0000_0000};
  endfunction

  // Channel addressed by frame k; the dummy frame k==n repeats the last entry.
  function automatic logic [2:0] frame_ch(input logic [7:0][2:0] list,
                                          input logic [3:0] n,
                                          input logic [3:0] k);
    logic [2:0] last;
    last = n[2:0] - 3'd1;
    if (k < n) begin
      return list[k[2:0]];
    end else begin
      return list[last];
    end
  endfunction

  state_t               r_state, w_state;
  logic [7:0]           r_div, w_div;
  logic [4:0]           r_half, w_half;   // SCLK half-period index: even=low, odd=high
  logic [3:0]           r_frame, w_frame;
  logic [3:0]           r_n, w_n;
  logic [7:0][2:0]      r_list, w_list;
  logic [3:0]           w_mask_n;
  logic [7:0][2:0]      w_mask_list;
  logic [SHIFT_W-1:0]   r_shift, w_shift;
  logic                 r_busy, w_busy;
  logic                 r_valid, w_valid;
  logic [2:0]           r_ch, w_ch;
  logic [11:0]          r_dout, w_dout;
  logic                 r_sclk, w_sclk;
  logic                 r_cs, w_cs;
  logic                 r_sdin, w_sdin;
  logic [15:0]          w_word, w_word_next, w_word0;
`ifdef ADC_FRAME_CHECK_EN
  logic                 r_err, w_err;
`endif

  // Compact ch_mask into an ascending channel list and count its entries.
  always_comb begin
    w_mask_list = '0;
    w_mask_n    = 4'd0;
    for (int i = 0; i < 8; i++) begin
      if (ch_mask[i]) begin
        w_mask_list[w_mask_n[2:0]] = 3'(i);
        w_mask_n = w_mask_n + 4'd1;
      end else begin
        w_mask_n = w_mask_n;
      end
    end
  end

  // Next-state and next-output logic for the scan FSM.
  always_comb begin
    w_state     = r_state;
    w_div       = r_div;
    w_half      = r_half;
    w_frame     = r_frame;
    w_n         = r_n;
    w_list      = r_list;
    w_shift     = r_shift;
    w_busy      = r_busy;
    w_valid     = 1'b0;
    w_ch        = r_ch;
    w_dout      = r_dout;
    w_sclk      = r_sclk;
    w_cs        = r_cs;
    w_sdin      = r_sdin;
`ifdef ADC_FRAME_CHECK_EN
    w_err       = r_err;
`endif
    w_word      = ctrl_word(frame_ch(r_list, r_n, r_frame));
    w_word_next = ctrl_word(frame_ch(r_list, r_n, r_frame + 4'd1));
    w_word0     = ctrl_word(w_mask_list[0]);
    case (r_state)
      S_IDLE: begin
        if (start && (ch_mask != 8'd0)) begin
          w_state = S_CS_SETUP;
          w_list  = w_mask_list;
          w_n     = w_mask_n;
          w_frame = 4'd0;
          w_div   = 8'd0;
          w_busy  = 1'b1;
          w_cs    = 1'b0;
          w_sclk  = 1'b1;
          w_sdin  = w_word0[15];
        end else begin
          w_state = S_IDLE;
        end
      end
      S_CS_SETUP: begin
        if (r_div == DIV_LAST) begin
          w_state = S_SHIFT;
          w_div   = 8'd0;
          w_half  = 5'd0;
          w_sclk  = 1'b0;
          w_sdin  = w_word[15];
        end else begin
          w_div = r_div + 8'd1;
        end
      end
      S_SHIFT: begin
        if (r_div != DIV_LAST) begin
          w_div = r_div + 8'd1;
        end else if (r_half == 5'd31) begin
          // Whole frame shifted in; frame 0 carries stale data and is dropped.
          w_div   = 8'd0;
          w_state = S_FRAME_END;
          if (r_frame != 4'd0) begin
            w_valid = 1'b1;
            w_ch    = frame_ch(r_list, r_n, r_frame - 4'd1);
            w_dout  = r_shift[11:0];
`ifdef ADC_FRAME_CHECK_EN
            w_err   = |r_shift[15:12];
`endif
          end else begin
            w_valid = 1'b0;
          end
        end else if (!r_half[0]) begin
          // Low phase ends: SCLK rises, capture DOUT.
          w_div   = 8'd0;
          w_half  = r_half + 5'd1;
          w_sclk  = 1'b1;
          w_shift = {r_shift[SHIFT_W-2:0], sdout};
        end else begin
          // High phase ends: SCLK falls into period p = r_half[4:1]+1, drive bit 15-p.
          w_div  = 8'd0;
          w_half = r_half + 5'd1;
          w_sclk = 1'b0;
          w_sdin = w_word[4'd14 - r_half[4:1]];
        end
      end
      S_FRAME_END: begin
        w_div  = 8'd0;
        w_half = 5'd0;
        if (r_frame < r_n) begin
          // Next frame follows immediately with CS still low.
          w_state = S_SHIFT;
          w_frame = r_frame + 4'd1;
          w_sclk  = 1'b0;
          w_sdin  = w_word_next[15];
        end else begin
          w_state = S_GAP;
          w_cs    = 1'b1;
          w_sclk  = 1'b1;
          w_sdin  = 1'b0;
        end
      end
      S_GAP: begin
        if (r_div == GAP_LAST) begin
          w_state = S_IDLE;
          w_busy  = 1'b0;
        end else begin
          w_div = r_div + 8'd1;
        end
      end
      default: begin
        w_state = S_IDLE;
        w_busy  = 1'b0;
        w_cs    = 1'b1;
        w_sclk  = 1'b1;
        w_sdin  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_div   <= 8'd0;
      r_half  <= 5'd0;
      r_frame <= 4'd0;
      r_n     <= 4'd0;
      r_list  <= '0;
      r_shift <= '0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_ch    <= 3'd0;
      r_dout  <= 12'd0;
      r_sclk  <= 1'b1;
      r_cs    <= 1'b1;
      r_sdin  <= 1'b0;
`ifdef ADC_FRAME_CHECK_EN
      r_err   <= 1'b0;
`endif
    end else begin
      r_state <= w_state;
      r_div   <= w_div;
      r_half  <= w_half;
      r_frame <= w_frame;
      r_n     <= w_n;
      r_list  <= w_list;
      r_shift <= w_shift;
      r_busy  <= w_busy;
      r_valid <= w_valid;
      r_ch    <= w_ch;
      r_dout  <= w_dout;
      r_sclk  <= w_sclk;
      r_cs    <= w_cs;
      r_sdin  <= w_sdin;
`ifdef ADC_FRAME_CHECK_EN
      r_err   <= w_err;
`endif
    end
  end

  assign busy       = r_busy;
  assign data_valid = r_valid;
  assign data_ch    = r_ch;
  assign data_out   = r_dout;
  assign sclk_out   = r_sclk;
  assign cs_out     = r_cs;
  assign sdin       = r_sdin;
`ifdef ADC_FRAME_CHECK_EN
  assign frame_err  = r_err;
`else
  assign frame_err  = 1'b0;
`endif

endmodule

// File: tb/tb_adc128s102_scan_ctrl.sv
// Testbench for adc128s102_scan_ctrl: directed and randomized scans against a
// behavioural ADC128S102 model plus an expected-result list built from the mask.
`timescale 1ns/1ps
module tb_adc128s102_scan_ctrl;

  localparam int CLK_DIV   = 2;
  localparam int BURST_GAP = 4;

  logic        sys_clk = 1'b0;
  logic        reset, start;
  logic [7:0]  ch_mask;
  logic        busy, data_valid, frame_err;
  logic [2:0]  data_ch;
  logic [11:0] data_out;
  logic        sdout, sclk_out, cs_out, sdin;

  adc128s102_scan_ctrl #(.CLK_DIV(CLK_DIV), .BURST_GAP(BURST_GAP)) dut (
    .sys_clk(sys_clk), .reset(reset), .start(start), .ch_mask(ch_mask),
    .busy(busy), .data_valid(data_valid), .data_ch(data_ch),
    .data_out(data_out), .frame_err(frame_err), .sdout(sdout),
    .sclk_out(sclk_out), .cs_out(cs_out), .sdin(sdin)
  );

  always #10 sys_clk = ~sys_clk;

  typedef struct {
    logic [2:0]  ch;
    logic [11:0] d;
    logic        e;
  } strobe_t;

  int n_assert = 0;
  int n_fail   = 0;

  // ADC contents and monitor records
  logic [11:0] adc_val [8];
  logic        adc_err [8];
  logic [15:0] din_q [$];
  strobe_t     obs_q [$];
  int          busy_cyc = 0;
  int          cs_low_cyc = 0;
  int          cs_fall = 0;

  logic        m_prev_cs = 1'b1;
  logic        m_prev_sclk = 1'b1;
  logic [4:0]  m_bit = 5'd0;
  logic [15:0] m_din = 16'd0;
  logic [15:0] m_out = 16'd0;

  // ADC model and bus monitor: DOUT changes on SCLK fall, DIN sampled on SCLK rise.
  always @(negedge sys_clk) begin
    if (busy === 1'b1) busy_cyc++;
    if (data_valid === 1'b1) obs_q.push_back('{data_ch, data_out, frame_err});
    if (cs_out !== 1'b0) begin
      m_bit = 5'd0;
      m_din = 16'd0;
      sdout = 1'b0;
    end else begin
      cs_low_cyc++;
      if (m_prev_cs) begin
        cs_fall++;
        m_out = 16'($urandom);
      end
      if (m_prev_sclk && (sclk_out === 1'b0)) sdout = m_out[4'd15 - m_bit[3:0]];
      if (!m_prev_sclk && (sclk_out === 1'b1)) begin
        m_din = {m_din[14:0], sdin};
        m_bit = m_bit + 5'd1;
        if (m_bit == 5'd16) begin
          din_q.push_back(m_din);
          m_out = {(adc_err[m_din[13:11]] ? 4'b1000 : 4'b0000), adc_val[m_din[13:11]]};
          m_bit = 5'd0;
        end
      end
    end
    m_prev_cs   = (cs_out !== 1'b0);
    m_prev_sclk = (sclk_out === 1'b1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clk_wait(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  // One full scan: expected results come straight from the mask and ADC table.
  task automatic run_burst(input logic [7:0] mask, input bit dbl);
    int b0, c0, f0, q0, d0, t, n, frames;
    strobe_t exp_q [$];
    logic [2:0] lastch;
    logic [2:0] fch;
    b0 = busy_cyc; c0 = cs_low_cyc; f0 = cs_fall; q0 = obs_q.size(); d0 = din_q.size();
    lastch = 3'd0;
    for (int ch = 0; ch < 8; ch++) begin
      if (mask[ch]) begin
`ifdef ADC_FRAME_CHECK_EN
        exp_q.push_back('{3'(ch), adc_val[ch], adc_err[ch]});
`else
        exp_q.push_back('{3'(ch), adc_val[ch], 1'b0});
`endif
        lastch = 3'(ch);
      end
    end
    n = exp_q.size();
    frames = n + 1;
    ch_mask = mask;
    start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    for (t = 0; t < 3000 && busy === 1'b1; t++) begin
      if (dbl && t == 40) start = 1'b1;
      if (dbl && t == 41) start = 1'b0;
      @(negedge sys_clk);
    end
    start = 1'b0;
    chk("burst_done", 32'(t < 3000), 32'd1);
    clk_wait(dbl ? 40 : 5);
    chk("busy_cycles", 32'(busy_cyc - b0), 32'(CLK_DIV + frames * (32 * CLK_DIV + 1) + BURST_GAP));
    chk("cs_low_cycles", 32'(cs_low_cyc - c0), 32'(CLK_DIV + frames * (32 * CLK_DIV + 1)));
    chk("cs_falls", 32'(cs_fall - f0), 32'd1);
    chk("busy_after", 32'(busy), 32'd0);
    chk("strobe_count", 32'(obs_q.size() - q0), 32'(n));
    chk("din_count", 32'(din_q.size() - d0), 32'(frames));
    for (int k = 0; k < n && (q0 + k) < obs_q.size(); k++) begin
      chk("data_ch", 32'(obs_q[q0 + k].ch), 32'(exp_q[k].ch));
      chk("data_out", 32'(obs_q[q0 + k].d), 32'(exp_q[k].d));
      chk("frame_err", 32'(obs_q[q0 + k].e), 32'(exp_q[k].e));
    end
    for (int k = 0; k < frames && (d0 + k) < din_q.size(); k++) begin
      fch = (k < n) ? exp_q[k].ch : lastch;
      chk("din_word", 32'(din_q[d0 + k]), 32'({2'b00, fch, 11'd0}));
    end
    if (n > 0) chk("data_hold", 32'(data_out), 32'(exp_q[n - 1].d));
  endtask

  initial begin
    int q0, q1, d0, f0, b0, t;
    reset = 1'b1; start = 1'b0; ch_mask = 8'd0;
    for (int i = 0; i < 8; i++) begin adc_val[i] = 12'd0; adc_err[i] = 1'b0; end
    clk_wait(5);
    reset = 1'b0;

    // Idle after reset
    q0 = obs_q.size(); f0 = cs_fall;
    clk_wait(100);
    chk("idle_cs", 32'(cs_out), 32'd1);
    chk("idle_sclk", 32'(sclk_out), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_dout", 32'(data_out), 32'd0);
    chk("idle_dch", 32'(data_ch), 32'd0);
    chk("idle_ferr", 32'(frame_err), 32'd0);
    chk("idle_no_strobe", 32'(obs_q.size() - q0), 32'd0);
    chk("idle_no_cs", 32'(cs_fall - f0), 32'd0);

    // Two-channel scan with known values
    adc_val[0] = 12'hABC; adc_val[2] = 12'h123;
    run_burst(8'h05, 1'b0);

    // Empty mask is ignored
    f0 = cs_fall; b0 = busy_cyc;
    ch_mask = 8'h00; start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    clk_wait(20);
    chk("zero_mask_cs", 32'(cs_fall - f0), 32'd0);
    chk("zero_mask_busy", 32'(busy_cyc - b0), 32'd0);

    // Start while busy is ignored
    adc_val[1] = 12'h5A5; adc_val[6] = 12'hFFF;
    run_burst(8'h42, 1'b1);

    // All channels
    for (int i = 0; i < 8; i++) adc_val[i] = 12'(12'h111 * (i + 1));
    run_burst(8'hFF, 1'b0);

    // Reset in frame 2 of a 0x0F scan
    d0 = din_q.size(); q0 = obs_q.size();
    ch_mask = 8'h0F; start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    for (t = 0; t < 1000 && din_q.size() < d0 + 2; t++) @(negedge sys_clk);
    chk("rst_wait", 32'(t < 1000), 32'd1);
    clk_wait(20);
    chk("rst_pre_strobes", 32'(obs_q.size() - q0), 32'd1);
    if (obs_q.size() > q0) chk("rst_pre_ch", 32'(obs_q[q0].ch), 32'd0);
    reset = 1'b1;
    @(negedge sys_clk);
    chk("rst_cs", 32'(cs_out), 32'd1);
    chk("rst_sclk", 32'(sclk_out), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(data_valid), 32'd0);
    chk("rst_dout", 32'(data_out), 32'd0);
    reset = 1'b0;
    q1 = obs_q.size();
    clk_wait(300);
    chk("rst_no_strobe", 32'(obs_q.size() - q1), 32'd0);
    chk("rst_idle_cs", 32'(cs_out), 32'd1);
    run_burst(8'h02, 1'b0);

    // Leading-bit error on the IN3 frame only
    adc_err[3] = 1'b1; adc_val[3] = 12'h3C3; adc_val[4] = 12'h404;
    run_burst(8'h18, 1'b0);
    adc_err[3] = 1'b0;

    // Randomized scans
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 8; i++) begin
        adc_val[i] = 12'($urandom);
        adc_err[i] = 1'($urandom);
      end
      run_burst(8'($urandom_range(1, 255)), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
